iact_cluster_tx: RTL and testbench
==================================

IACT_CLUSTER_TX -- requirements
Module: iact_cluster_tx

Interface
REQ-001 Parameter DATA_WIDTH, default `HWC_IACT_BUFFER_WIDTH, iact word width.
REQ-002 Parameter SET_WIDTH, default `HWC_PE_CLUSTER_IACT_ROUT_CONFIG_SET_SIZE_WIDTH, data-set tag width.
REQ-003 Parameter CNT_WIDTH, default `HWC_IACT_ADDR_SPAD_WIDTH, words-per-set counter width.
REQ-004 Parameter FIFO_DEPTH, default 4, staging entries (power of two, >=2).
REQ-005 Ports, as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job launch.
- words_per_set  in  CNT_WIDTH  words per data set; sampled on accepted start.
- last_set  in  SET_WIDTH  index of final set; sampled on accepted start.
- src_valid  in  1  source word valid.
- src_data  in  DATA_WIDTH  source word.
- src_ready  out  1  block accepts the source word this cycle.
- iact_enable  out  1  word valid toward the cluster iact channel.
- iact_data_in_packed  out  DATA_WIDTH  word toward the cluster.
- iact_data_set  out  SET_WIDTH  set tag of the presented word.
- iact_ready  in  1  cluster channel ready.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job completion.

Function
REQ-006 The block is the sending end of one cluster iact channel: it streams last_set+1 sets of words_per_set words each, tagging every word with its set index.
REQ-007 FSM states IDLE, SEND, DRAIN; after reset the FSM is in IDLE.
REQ-008 IDLE->SEND on start with words_per_set!=0; with words_per_set==0, start is ignored; start outside IDLE is ignored.
REQ-009 In SEND, src_ready = !fifo_full; push = src_valid && src_ready; each pushed word is stored with its tag set_cnt.
REQ-010 A push counter word_cnt increments per push; when word_cnt==words_per_set-1, word_cnt wraps to 0 and set_cnt increments.
REQ-011 The push of word words_per_set-1 of set last_set moves SEND->DRAIN; src_ready is 0 in IDLE and DRAIN.
REQ-012 iact_enable = !fifo_empty; iact_data_in_packed and iact_data_set come from the FIFO head.
REQ-013 Pop = iact_enable && iact_ready; with iact_enable high and iact_ready low, head data and tag stay stable.
REQ-014 Latency: a word pushed in cycle t into an empty FIFO has iact_enable high in cycle t+1. There is no bypass path.
REQ-015 A simultaneous push and pop is allowed when the FIFO is neither empty nor full; when full, src_ready is 0 even if a pop occurs that cycle.
REQ-016 DRAIN->IDLE when the FIFO becomes empty after a pop; done is 1 for exactly the following cycle; busy is 1 in SEND and DRAIN.
REQ-017 FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; occupancy is a separate counter of width log2(FIFO_DEPTH)+1.
REQ-018 When last_set is the maximum value of SET_WIDTH, set_cnt reaches it without overflowing; completion is detected by comparison, not by wrap.

Reset
REQ-019 rst asserted at any time clears the FSM to IDLE, clears the FIFO pointers, occupancy, word_cnt and set_cnt, and drives busy, done, src_ready and iact_enable to 0.
REQ-020 Reset mid-job discards all buffered words; no done pulse is generated for the aborted job.
REQ-021 iact_data_in_packed and iact_data_set reset to 0.

Structure
REQ-022 Width defaults come from hw_config.vh macros; the FSM state encodings go in a shared iact_tx_pkg header.
REQ-023 The staging buffer is one sub-module, Sync_Fifo (data+tag width, depth parameter), reusable by other router transmitters.

Verification
REQ-024 words_per_set=3, last_set=1, src_valid and iact_ready held 1: 6 words out in order, tags 0,0,0,1,1,1, first iact_enable one cycle after the first push, done pulse once, busy then 0.
REQ-025 iact_ready held 0 with src_valid 1: src_ready drops after 4 pushes; head word and tag stay stable; releasing iact_ready drains all words in order.
REQ-026 Random src_valid/iact_ready toggling, words_per_set=5, last_set=3: 20 words, tags 0..3 five each, no loss or duplication.
REQ-027 start with words_per_set=0: busy stays 0, src_ready stays 0, no done; start while busy leaves the job unchanged.
REQ-028 rst pulsed after 2 of 6 words: all outputs 0 the next cycle, FIFO empty, no done; a new start then runs a full job correctly.
REQ-029 SET_WIDTH=2, last_set=3, words_per_set=1: tags 0,1,2,3, then done; no tag wrap before done.

Source files
------------

// File: rtl/iact_tx_pkg.sv
// Shared definitions for iact router transmitters: width defaults and FSM encoding.
package iact_tx_pkg;

  // Platform width defaults used as parameter defaults by the transmitters.
  localparam int HWC_IACT_BUFFER_WIDTH                     = 16;
  localparam int HWC_PE_CLUSTER_IACT_ROUT_CONFIG_SET_SIZE_WIDTH = 2;
  localparam int HWC_IACT_ADDR_SPAD_WIDTH                  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

endpackage

// File: rtl/iact_cluster_tx_sync_fifo.sv
// Sync_Fifo: single-clock staging FIFO with occupancy counter, head visible combinationally.
module Sync_Fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // An empty FIFO presents zeros so the head never shows stale storage.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH; occupancy tracked separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iact_cluster_tx.sv
// Sending end of one cluster iact channel: streams (last_set+1) x words_per_set tagged words.
module iact_cluster_tx
  import iact_tx_pkg::*;
#(
  parameter int DATA_WIDTH = HWC_IACT_BUFFER_WIDTH,
  parameter int SET_WIDTH  = HWC_PE_CLUSTER_IACT_ROUT_CONFIG_SET_SIZE_WIDTH,
  parameter int CNT_WIDTH  = HWC_IACT_ADDR_SPAD_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  words_per_set,
  input  logic [SET_WIDTH-1:0]  last_set,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  iact_enable,
  output logic [DATA_WIDTH-1:0] iact_data_in_packed,
  output logic [SET_WIDTH-1:0]  iact_data_set,
  input  logic                  iact_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = DATA_WIDTH + SET_WIDTH;

  tx_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] wps_q;
  logic [SET_WIDTH-1:0] last_q;
  logic [CNT_WIDTH-1:0] word_cnt;
  logic [SET_WIDTH-1:0] set_cnt;
  logic                 done_q;

  logic                 fifo_full, fifo_empty;
  logic [AW:0]          fifo_count;
  logic [FW-1:0]        fifo_head;
  logic                 push, pop;
  logic                 start_ok;
  logic                 word_end, set_end, last_push;

  assign start_ok  = (state_q == ST_IDLE) && start && (words_per_set != '0);
  assign src_ready = (state_q == ST_SEND) && !fifo_full;
  assign push      = src_valid && src_ready;
  assign pop       = iact_enable && iact_ready;
  assign word_end  = (word_cnt == wps_q - CNT_WIDTH'(1));
  // Completion is a compare against last_q, so a last_set at max value never wraps.
  assign set_end   = (set_cnt == last_q);
  assign last_push = push && word_end && set_end;

  assign iact_enable         = !fifo_empty;
  assign iact_data_in_packed = fifo_head[FW-1:SET_WIDTH];
  assign iact_data_set       = fifo_head[SET_WIDTH-1:0];
  assign busy                = (state_q != ST_IDLE);
  assign done                = done_q;

  Sync_Fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({src_data, set_cnt}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state logic; DRAIN ends on the pop that takes the last buffered word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_SEND;
      ST_SEND:  if (last_push) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && fifo_count == (AW+1)'(1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and one-cycle done pulse after the final pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
    end
  end

  // Job config capture and word/set counters; set_cnt holds on the final word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wps_q    <= '0;
      last_q   <= '0;
      word_cnt <= '0;
      set_cnt  <= '0;
    end else if (start_ok) begin
      wps_q    <= words_per_set;
      last_q   <= last_set;
      word_cnt <= '0;
      set_cnt  <= '0;
    end else if (push) begin
      if (word_end) begin
        word_cnt <= '0;
        if (!set_end) set_cnt <= set_cnt + SET_WIDTH'(1);
      end else begin
        word_cnt <= word_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_iact_cluster_tx.sv
// Scoreboard bench for iact_cluster_tx: driver queues expected words, monitor checks handshakes.
module tb_iact_cluster_tx;

  localparam int DW = 16;
  localparam int SW = 2;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] words_per_set = '0;
  logic [SW-1:0] last_set = '0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic          iact_enable;
  logic [DW-1:0] iact_data_in_packed;
  logic [SW-1:0] iact_data_set;
  logic          iact_ready = 1'b0;
  logic          busy;
  logic          done;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   first_en = -1;
  exp_t sb[$];

  iact_cluster_tx #(
    .DATA_WIDTH (DW),
    .SET_WIDTH  (SW),
    .CNT_WIDTH  (CW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .words_per_set       (words_per_set),
    .last_set            (last_set),
    .src_valid           (src_valid),
    .src_data            (src_data),
    .src_ready           (src_ready),
    .iact_enable         (iact_enable),
    .iact_data_in_packed (iact_data_in_packed),
    .iact_data_set       (iact_data_set),
    .iact_ready          (iact_ready),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every handshake pops one expected word; done pulses are counted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (done) done_cnt++;
        if (iact_enable) begin
          if (first_en < 0) first_en = cyc;
          if (iact_ready) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL extra_word: got %0h tag %0d with nothing expected", iact_data_in_packed, iact_data_set);
            end else begin
              e = sb.pop_front();
              check("word", {14'd0, iact_data_set, iact_data_in_packed}, {14'd0, e.t, e.d});
            end
          end
        end
      end
    end
  end

  task automatic push_expected(input int wps, input int last, input int base);
    for (int i = 0; i < (last + 1) * wps; i++)
      sb.push_back('{d: DW'(base + i), t: SW'(i / wps)});
  endtask

  task automatic pulse_start(input int wps, input int last);
    @(negedge clk);
    start = 1'b1;
    words_per_set = CW'(wps);
    last_set = SW'(last);
  endtask

  // rmode: 0 ready held high, 1 random, 2 held low for 12 cycles then high.
  task automatic run_job(input int wps, input int last, input int base, input int rmode,
                         input bit vrand, input bit mid_start, input bit lat_chk);
    int n;
    int idx;
    int first_push;
    int d0;
    bit got;
    n = (last + 1) * wps;
    idx = 0;
    first_push = -1;
    d0 = done_cnt;
    got = 1'b0;
    push_expected(wps, last, base);
    first_en = -1;
    pulse_start(wps, last);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = mid_start && (k == 3);
      words_per_set = (mid_start && k == 3) ? CW'(7) : CW'(wps);
      last_set = (mid_start && k == 3) ? SW'(0) : SW'(last);
      src_valid = (idx < n) && (vrand ? ($urandom_range(0, 1) == 1) : 1'b1);
      src_data = (idx < n) ? DW'(base + idx) : '0;
      case (rmode)
        0:       iact_ready = 1'b1;
        1:       iact_ready = ($urandom_range(0, 1) == 1);
        default: iact_ready = (k >= 12);
      endcase
      #1;
      if (src_valid && src_ready) begin
        if (first_push < 0) first_push = cyc;
        idx++;
      end
      if (rmode == 2 && (k == 8 || k == 11)) begin
        check("stall_pushes", idx, 4);
        check("stall_src_ready", src_ready, 0);
        check("stall_enable", iact_enable, 1);
        check("stall_head", {iact_data_set, iact_data_in_packed}, {SW'(0), DW'(base)});
      end
      #1;
      if (done_cnt > d0) begin
        got = 1'b1;
        break;
      end
    end
    src_valid = 1'b0;
    iact_ready = 1'b0;
    check("done_seen", got, 1);
    repeat (2) @(negedge clk);
    #2;
    check("done_once", done_cnt - d0, 1);
    check("busy_after", busy, 0);
    check("all_pushed", idx, n);
    check("sb_empty", sb.size(), 0);
    if (lat_chk) check("first_latency", first_en - first_push, 1);
    sb.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_src_ready"}, src_ready, 0);
    check({tag, "_enable"}, iact_enable, 0);
    check({tag, "_data"}, iact_data_in_packed, 0);
    check({tag, "_set"}, iact_data_set, 0);
  endtask

  initial begin
    int d0;
    int idx;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("reset");

    // Basic stream: 2 sets of 3 words, no back-pressure.
    run_job(3, 1, 'h100, 0, 1'b0, 1'b0, 1'b1);

    // Cluster stalled: FIFO fills to 4, head holds, then drains in order.
    run_job(3, 1, 'h200, 2, 1'b0, 1'b0, 1'b0);

    // Random valid/ready on both sides.
    run_job(5, 3, 'h300, 1, 1'b1, 1'b0, 1'b0);

    // Zero-length start is ignored.
    d0 = done_cnt;
    pulse_start(0, 1);
    src_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zero_busy", busy, 0);
    check("zero_src_ready", src_ready, 0);
    repeat (3) @(negedge clk);
    #2;
    check("zero_no_done", done_cnt - d0, 0);
    check("zero_enable", iact_enable, 0);
    src_valid = 1'b0;

    // Start while busy does not disturb the running job.
    run_job(2, 1, 'h400, 0, 1'b0, 1'b1, 1'b0);

    // Reset mid-job after two accepted words.
    d0 = done_cnt;
    idx = 0;
    push_expected(3, 1, 'h500);
    pulse_start(3, 1);
    for (int k = 0; k < 20 && idx < 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      src_valid = 1'b1;
      src_data = DW'('h500 + idx);
      iact_ready = 1'b1;
      #1;
      if (src_valid && src_ready) idx++;
    end
    check("rst_prefix_pushes", idx, 2);
    @(negedge clk);
    rst = 1'b1;
    src_valid = 1'b0;
    iact_ready = 1'b0;
    #1;
    sb.delete();
    check_idle_outputs("in_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("post_rst");
    repeat (3) @(negedge clk);
    #2;
    check("rst_no_done", done_cnt - d0, 0);
    run_job(3, 1, 'h600, 0, 1'b0, 1'b0, 1'b0);

    // Max-valued last_set: tags 0..3 with no wrap before done.
    run_job(1, 3, 'h700, 0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
